// File: rtl/cfu_cmd_sequencer.sv
`timescale 1ns/1ps
// CFU command front-end: decodes custom-instruction functions, owns the
// A/B/C buffer address muxing and sequences blocking/non-blocking TPU launches.
module cfu_cmd_sequencer #(
  parameter int A_BITS  = 15,
  parameter int B_BITS  = 15,
  parameter int C_BITS  = 10,
  parameter int C_LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [9:0]            cmd_payload_function_id,
  input  logic [31:0]           cmd_payload_inputs_0,
  input  logic [31:0]           cmd_payload_inputs_1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_payload_outputs_0,
  output logic                  a_wr_en,
  output logic                  b_wr_en,
  output logic [A_BITS-1:0]     a_index,
  output logic [B_BITS-1:0]     b_index,
  output logic [31:0]           a_wdata,
  output logic [31:0]           b_wdata,
  output logic [C_BITS-1:0]     c_index,
  input  logic [32*C_LANES-1:0] c_rdata,
  output logic                  tpu_in_valid,
  output logic [10:0]           tpu_k,
  output logic [11:0]           tpu_m,
  output logic [8:0]            tpu_n,
  output logic [31:0]           tpu_input_offset,
  input  logic                  tpu_busy,
  input  logic [A_BITS-1:0]     tpu_a_index,
  input  logic [B_BITS-1:0]     tpu_b_index,
  input  logic [C_BITS-1:0]     tpu_c_index
);

  // IDLE: accept commands | READ: C data arriving | CALC: blocking GO | RESP: hold response
  typedef enum logic [1:0] {IDLE, READ, CALC, RESP} state_t;

  localparam logic [2:0] FN_WRITE_A  = 3'd0;
  localparam logic [2:0] FN_WRITE_B  = 3'd1;
  localparam logic [2:0] FN_READ_C   = 3'd2;
  localparam logic [2:0] FN_GO       = 3'd3;
  localparam logic [2:0] FN_GO_ASYNC = 3'd4;
  localparam logic [2:0] FN_STATUS   = 3'd5;
  localparam logic [2:0] FN_SET_PTR  = 3'd6;

  state_t            state, state_nxt;
  logic [2:0]        fn;
  logic              auto_inc;
  logic              accept;
  logic              start;
  logic              tpu_mode;
  logic              job_done;
  logic              run;
  logic [A_BITS-1:0] a_ptr;
  logic [B_BITS-1:0] b_ptr;
  logic [31:0]       count;
  logic [31:0]       count_inc;
  logic [2:0]        lane;
  logic [31:0]       lane_data;
  logic [31:0]       rsp_data;
  logic              unused_fn_bits;

  assign fn             = cmd_payload_function_id[5:3];
  assign auto_inc       = cmd_payload_function_id[0];
  assign unused_fn_bits = ^{cmd_payload_function_id[9:6], cmd_payload_function_id[2:1]};
  assign cmd_ready      = (state == IDLE) && (!run || fn == FN_STATUS);
  assign accept         = cmd_valid && cmd_ready;
  assign start          = accept && (fn == FN_GO || fn == FN_GO_ASYNC);
  assign tpu_mode       = (state == CALC) || run;
  // The start pulse cycle never counts as "done": the TPU may raise busy late.
  assign job_done       = !tpu_in_valid && !tpu_busy;
  assign count_inc      = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
  assign a_wdata        = cmd_payload_inputs_0;
  assign b_wdata        = cmd_payload_inputs_0;
  assign rsp_payload_outputs_0 = rsp_data;

  // Lane 0 is the most significant 32 bits of the C word.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < C_LANES; i++) begin
      if (lane == 3'(i)) lane_data = c_rdata[32*(C_LANES-i)-1 -: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    a_wr_en   = 1'b0;
    b_wr_en   = 1'b0;
    a_index   = tpu_a_index;
    b_index   = tpu_b_index;
    c_index   = tpu_c_index;
    if (!tpu_mode) begin
      a_index = auto_inc ? a_ptr : cmd_payload_inputs_1[A_BITS-1:0];
      b_index = auto_inc ? b_ptr : cmd_payload_inputs_1[B_BITS-1:0];
      c_index = cmd_payload_inputs_1[C_BITS-1:0];
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RESP;
          case (fn)
            FN_WRITE_A: a_wr_en   = 1'b1;
            FN_WRITE_B: b_wr_en   = 1'b1;
            FN_READ_C:  state_nxt = READ;
            FN_GO:      state_nxt = CALC;
            default:    state_nxt = RESP;
          endcase
        end
      end
      READ: state_nxt = RESP;
      CALC: if (job_done) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ptr            <= '0;
      b_ptr            <= '0;
      count            <= '0;
      run              <= 1'b0;
      lane             <= '0;
      rsp_data         <= '0;
      tpu_in_valid     <= 1'b0;
      tpu_k            <= '0;
      tpu_m            <= '0;
      tpu_n            <= '0;
      tpu_input_offset <= '0;
    end else begin
      tpu_in_valid <= start;
      if (start) begin
        tpu_k            <= cmd_payload_inputs_0[31:21];
        tpu_m            <= cmd_payload_inputs_0[20:9];
        tpu_n            <= cmd_payload_inputs_0[8:0];
        tpu_input_offset <= cmd_payload_inputs_1;
        count            <= '0;
      end else if (tpu_mode) begin
        count <= count_inc;
      end

      if (run && job_done) run <= 1'b0;
      if (accept && fn == FN_GO_ASYNC) run <= 1'b1;

      if (accept && fn == FN_SET_PTR) begin
        a_ptr <= cmd_payload_inputs_0[A_BITS-1:0];
        b_ptr <= cmd_payload_inputs_1[B_BITS-1:0];
      end else begin
        if (a_wr_en && auto_inc) a_ptr <= a_ptr + 1'b1;
        if (b_wr_en && auto_inc) b_ptr <= b_ptr + 1'b1;
      end

      if (accept && fn == FN_READ_C) lane <= cmd_payload_inputs_0[2:0];

      if (accept) begin
        case (fn)
          FN_STATUS: rsp_data <= {run, count[30:0]};
          3'd7:      rsp_data <= 32'hFFFF_FFFF;
          default:   rsp_data <= '0;
        endcase
      end else if (state == READ) begin
        rsp_data <= lane_data;
      end else if (state == CALC && job_done) begin
        rsp_data <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for cfu_cmd_sequencer: directed scenarios plus a randomized
// command stream checked against a transaction-level reference model.
module tb_cfu_cmd_sequencer;
  localparam int A_BITS  = 15;
  localparam int B_BITS  = 4;
  localparam int C_BITS  = 10;
  localparam int C_LANES = 4;
  localparam int CW      = 32 * C_LANES;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_payload_function_id;
  logic [31:0]       cmd_payload_inputs_0;
  logic [31:0]       cmd_payload_inputs_1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_payload_outputs_0;
  logic              a_wr_en, b_wr_en;
  logic [A_BITS-1:0] a_index;
  logic [B_BITS-1:0] b_index;
  logic [31:0]       a_wdata, b_wdata;
  logic [C_BITS-1:0] c_index;
  logic [CW-1:0]     c_rdata;
  logic              tpu_in_valid;
  logic [10:0]       tpu_k;
  logic [11:0]       tpu_m;
  logic [8:0]        tpu_n;
  logic [31:0]       tpu_input_offset;
  logic              tpu_busy;
  logic [A_BITS-1:0] tpu_a_index;
  logic [B_BITS-1:0] tpu_b_index;
  logic [C_BITS-1:0] tpu_c_index;

  cfu_cmd_sequencer #(.A_BITS(A_BITS), .B_BITS(B_BITS), .C_BITS(C_BITS), .C_LANES(C_LANES)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en), .a_index(a_index), .b_index(b_index),
    .a_wdata(a_wdata), .b_wdata(b_wdata), .c_index(c_index), .c_rdata(c_rdata),
    .tpu_in_valid(tpu_in_valid), .tpu_k(tpu_k), .tpu_m(tpu_m), .tpu_n(tpu_n),
    .tpu_input_offset(tpu_input_offset), .tpu_busy(tpu_busy),
    .tpu_a_index(tpu_a_index), .tpu_b_index(tpu_b_index), .tpu_c_index(tpu_c_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] rsp_exp_q[$];
  logic [31:0] rsp_mask_q[$];
  logic [63:0] a_exp_q[$];
  logic [63:0] b_exp_q[$];
  logic [63:0] tpu_exp_q[$];

  // reference model state
  int          m_a_ptr = 0;
  int          m_b_ptr = 0;
  logic [31:0] m_count = 0;
  bit          m_run   = 0;
  int          m_pulses = 0;
  int          pulses = 0;

  int next_dur = 0;
  int busy_left = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  function automatic logic [CW-1:0] c_word(input logic [C_BITS-1:0] idx);
    logic [CW-1:0] w;
    if (idx == C_BITS'(5)) return 128'h11111111_22222222_33333333_44444444;
    w = '0;
    for (int p = 0; p < C_LANES; p++) w[32*p +: 32] = 32'hA500_0000 | (32'(idx) << 8) | 32'(p);
    return w;
  endfunction

  function automatic logic [31:0] lane_exp(input logic [CW-1:0] w, input int lane);
    logic [CW-1:0] sh;
    if (lane >= C_LANES) return 32'h0;
    sh = w >> (32 * (C_LANES - 1 - lane));
    return sh[31:0];
  endfunction

  // behavioural C buffer and TPU
  always @(posedge clk) c_rdata <= c_word(c_index);

  always @(posedge clk) begin
    if (reset)              busy_left <= 0;
    else if (tpu_in_valid)  busy_left <= next_dur;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tpu_busy = (busy_left != 0);

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor: compares everything the DUT presents against the queues
  logic [63:0] mon_e;
  logic [31:0] mon_r, mon_m;
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        check("rsp_valid_with_cmd_ready", 32'(cmd_ready), 32'd0);
        if (rsp_exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          mon_r = rsp_exp_q[0];
          mon_m = rsp_mask_q[0];
          check("rsp_data", rsp_payload_outputs_0 & mon_m, mon_r & mon_m);
          if (rsp_ready) begin
            void'(rsp_exp_q.pop_front());
            void'(rsp_mask_q.pop_front());
          end
        end
      end
      if (a_wr_en) begin
        if (a_exp_q.size() == 0) check("a_wr_unexpected", 32'(a_wr_en), 32'd0);
        else begin
          mon_e = a_exp_q.pop_front();
          check("a_index", 32'(a_index), mon_e[63:32]);
          check("a_wdata", a_wdata, mon_e[31:0]);
        end
      end
      if (b_wr_en) begin
        if (b_exp_q.size() == 0) check("b_wr_unexpected", 32'(b_wr_en), 32'd0);
        else begin
          mon_e = b_exp_q.pop_front();
          check("b_index", 32'(b_index), mon_e[63:32]);
          check("b_wdata", b_wdata, mon_e[31:0]);
        end
      end
      if (tpu_in_valid) begin
        pulses++;
        if (tpu_exp_q.size() == 0) check("tpu_pulse_unexpected", 32'(tpu_in_valid), 32'd0);
        else begin
          mon_e = tpu_exp_q.pop_front();
          check("tpu_kmn", {tpu_k, tpu_m, tpu_n}, mon_e[63:32]);
          check("tpu_offset", tpu_input_offset, mon_e[31:0]);
        end
      end
    end
  end

  task automatic push_rsp(input logic [31:0] r, input logic [31:0] m);
    rsp_exp_q.push_back(r);
    rsp_mask_q.push_back(m);
  endtask

  task automatic wait_drain();
    int n = 0;
    bit seen_ready = 0;
    while (rsp_exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (cmd_ready && rsp_exp_q.size() != 0) seen_ready = 1;
    end
    if (rsp_exp_q.size() != 0) fail("rsp_timeout", rsp_exp_q.size(), 0);
    check("cmd_ready_while_busy", 32'(seen_ready), 32'd0);
  endtask

  task automatic drive_cmd(input logic [2:0] fn, input bit ai, input logic [31:0] in0, input logic [31:0] in1);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {4'b0, fn, 2'b0, ai};
    cmd_payload_inputs_0 = in0;
    cmd_payload_inputs_1 = in1;
  endtask

  task automatic send(input logic [2:0] fn, input bit ai, input logic [31:0] in0, input logic [31:0] in1);
    int n = 0;
    drive_cmd(fn, ai, in0, in1);
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) fail("accept_timeout", n, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    wait_drain();
  endtask

  task automatic do_write(input bit is_b, input bit ai, input logic [31:0] data, input logic [31:0] in1);
    int addr;
    if (!is_b) begin
      addr = ai ? m_a_ptr : int'(in1) & ((1 << A_BITS) - 1);
      if (ai) m_a_ptr = (m_a_ptr + 1) % (1 << A_BITS);
      a_exp_q.push_back({32'(addr), data});
    end else begin
      addr = ai ? m_b_ptr : int'(in1) & ((1 << B_BITS) - 1);
      if (ai) m_b_ptr = (m_b_ptr + 1) % (1 << B_BITS);
      b_exp_q.push_back({32'(addr), data});
    end
    push_rsp(32'h0, 32'hFFFF_FFFF);
    send(is_b ? 3'd1 : 3'd0, ai, data, in1);
  endtask

  task automatic do_set_ptr(input logic [31:0] pa, input logic [31:0] pb);
    m_a_ptr = int'(pa) & ((1 << A_BITS) - 1);
    m_b_ptr = int'(pb) & ((1 << B_BITS) - 1);
    push_rsp(32'h0, 32'hFFFF_FFFF);
    send(3'd6, 1'b0, pa, pb);
  endtask

  task automatic do_read(input int idx, input int lane);
    logic [31:0] in0, in1;
    in0 = ($urandom & 32'hFFFF_FFF8) | 32'(lane);
    in1 = ($urandom & ~32'((1 << C_BITS) - 1)) | 32'(idx);
    push_rsp(lane_exp(c_word(C_BITS'(idx)), lane), 32'hFFFF_FFFF);
    send(3'd2, 1'b0, in0, in1);
  endtask

  task automatic do_go(input logic [31:0] in0, input logic [31:0] in1, input int dur);
    next_dur = dur;
    tpu_exp_q.push_back({in0, in1});
    m_pulses++;
    m_count = 32'(dur + 2);
    push_rsp(m_count, 32'hFFFF_FFFF);
    send(3'd3, 1'b0, in0, in1);
  endtask

  task automatic do_status();
    push_rsp({m_run, m_count[30:0]}, 32'hFFFF_FFFF);
    send(3'd5, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reserved();
    push_rsp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(3'd7, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int p0, mism, n, op;
  bit done_seen;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0; cmd_payload_inputs_1 = '0; rsp_ready = 1'b1;
    tpu_a_index = 15'h5A5A; tpu_b_index = 4'h9; tpu_c_index = 10'h2C3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    check("rst_tpu_in_valid", 32'(tpu_in_valid), 32'd0);
    check("rst_tpu_kmn", {tpu_k, tpu_m, tpu_n}, 32'd0);
    check("rst_tpu_offset", tpu_input_offset, 32'd0);
    check("rst_a_wr_en", 32'(a_wr_en), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    do_status();

    // pointers and auto-increment, including the B wrap
    do_set_ptr(32'h10, 32'h20);
    do_write(0, 1, 32'd1, $urandom);
    do_write(0, 1, 32'd2, $urandom);
    do_write(0, 1, 32'd3, $urandom);
    do_write(0, 0, 32'hDEAD_BEEF, 32'h1234_4321);
    do_set_ptr(32'h10, 32'd15);
    do_write(1, 1, 32'hB0B0_0001, $urandom);
    do_write(1, 1, 32'hB0B0_0002, $urandom);
    do_write(1, 0, 32'hB0B0_0003, 32'h0000_0007);

    // C lane readback
    for (int l = 0; l < 4; l++) do_read(5, l);
    do_read(5, 5);
    rsp_ready = 1'b0;
    fork
      do_read(5, 2);
      begin
        int w;
        w = 0;
        while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join

    // blocking GO
    p0 = pulses;
    do_go({11'd16, 12'd32, 9'd4}, 32'hFFFF_FF80, 50);
    check("go_one_pulse", 32'(pulses - p0), 32'd1);
    do_status();

    do_reserved();

    // non-blocking GO with status polling and a gated WRITE_A
    next_dur = 40;
    tpu_exp_q.push_back({32'h0040_2008, 32'h0000_0011});
    m_pulses++;
    push_rsp(32'h0, 32'hFFFF_FFFF);
    send(3'd4, 1'b0, 32'h0040_2008, 32'h0000_0011);
    push_rsp(32'h8000_0000, 32'h8000_0000);
    send(3'd5, 1'b0, $urandom, $urandom);
    tpu_a_index = 15'h1357; tpu_b_index = 4'h3; tpu_c_index = 10'h155;
    a_exp_q.push_back({32'h0000_0123, 32'hCAFE_F00D});
    push_rsp(32'h0, 32'hFFFF_FFFF);
    drive_cmd(3'd0, 1'b0, 32'hCAFE_F00D, 32'h0000_0123);
    done_seen = 0; mism = 0; n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (cmd_ready !== done_seen) mism++;
      if (done_seen) break;
      if (a_index !== tpu_a_index || b_index !== tpu_b_index || c_index !== tpu_c_index) mism++;
      if (a_wr_en || b_wr_en) mism++;
      if (!tpu_busy && !tpu_in_valid) done_seen = 1;
    end
    check("async_gate_mismatches", 32'(mism), 32'd0);
    check("async_job_ended", 32'(done_seen), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain();
    m_run = 0;
    m_count = 32'd42;
    do_status();
    do_status();

    // reset in the middle of CALC
    do_set_ptr(32'h77, 32'd3);
    next_dur = 50;
    tpu_exp_q.push_back({32'h0020_0401, 32'h0});
    m_pulses++;
    drive_cmd(3'd3, 1'b0, 32'h0020_0401, 32'h0);
    @(negedge clk);
    check("rst_go_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("calc_cycle10_busy", 32'(cmd_ready), 32'd0);
    reset = 1'b1;
    rsp_exp_q.delete(); rsp_mask_q.delete();
    m_a_ptr = 0; m_b_ptr = 0; m_count = 0; m_run = 0;
    @(negedge clk);
    check("midcalc_rst_idle", 32'(cmd_ready), 32'd1);
    check("midcalc_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midcalc_rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    check("midcalc_rst_kmn", {tpu_k, tpu_m, tpu_n}, 32'd0);
    reset = 1'b0;
    do_write(0, 1, 32'h0A0A_0A0A, $urandom);
    do_write(1, 1, 32'h0B0B_0B0B, $urandom);
    do_status();

    // randomized command stream
    rand_ready = 1;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: do_write(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        1: do_write(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        2: do_read(($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, (1 << C_BITS) - 1), $urandom_range(0, 7));
        3: do_go($urandom, $urandom, $urandom_range(0, 6));
        4: do_status();
        5: do_set_ptr($urandom, $urandom);
        default: do_reserved();
      endcase
    end
    rand_ready = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("pulse_count", 32'(pulses), 32'(m_pulses));
    check("a_writes_left", 32'(a_exp_q.size()), 32'd0);
    check("b_writes_left", 32'(b_exp_q.size()), 32'd0);
    check("tpu_starts_left", 32'(tpu_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfu_cmd_sequencer.md
Name: cfu_cmd_sequencer

Overview:
- Parametrised command front-end between the CPU custom-instruction port and the A/B/C global buffers plus the TPU core.
- Decodes an 8-entry function set and owns the buffer address muxing.
- Adds auto-increment write pointers, generic C-lane readback, non-blocking launch with status polling, and a cycle counter.
- Buffers and TPU are instantiated outside this block and connected through its ports.

Parameters:
- A_BITS, 15, A buffer address width.
- B_BITS, 15, B buffer address width.
- C_BITS, 10, C buffer address width.
- C_LANES, 4, number of 32-bit lanes per C word (1..8); C word width = 32*C_LANES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_payload_function_id  in  10  function code in [5:3]; bit [0] = auto-increment select
- cmd_payload_inputs_0  in  32  operand 0
- cmd_payload_inputs_1  in  32  operand 1
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_payload_outputs_0  out  32  response data
- a_wr_en, b_wr_en  out  1  buffer write strobes
- a_index / b_index  out  A_BITS / B_BITS  buffer addresses
- a_wdata / b_wdata  out  32  write data (= inputs_0)
- c_index  out  C_BITS  C buffer address
- c_rdata  in  32*C_LANES  C read data, valid 1 cycle after address
- tpu_in_valid  out  1  one-cycle start pulse
- tpu_k / tpu_m / tpu_n  out  11 / 12 / 9  = inputs_0[31:21] / [20:9] / [8:0], registered on GO
- tpu_input_offset  out  32  = inputs_1, registered on GO
- tpu_busy  in  1  TPU running
- tpu_a_index / tpu_b_index / tpu_c_index  in  A_BITS / B_BITS / C_BITS  TPU-driven addresses

Behaviour:
- Function codes: 0 WRITE_A, 1 WRITE_B, 2 READ_C, 3 GO (blocking), 4 GO_ASYNC, 5 STATUS, 6 SET_PTR, 7 reserved.
- States: IDLE, READ, CALC, RESP. Reset forces IDLE with the following values:
  - a_ptr, b_ptr, cycle counter, run flag = 0
  - tpu_in_valid, a_wr_en, b_wr_en, rsp_valid = 0
  - rsp_payload_outputs_0 = 0
  - tpu_k/m/n and tpu_input_offset = 0
- Reset mid-CALC or mid-RESP aborts immediately. An unacknowledged response is dropped.
- cmd_ready is 1 in IDLE only. Commands are accepted on cmd_valid && cmd_ready.
- While run=1 (async job active), only STATUS is accepted; any other code holds cmd_ready=0 until run clears.
- WRITE_A / WRITE_B:
  - Write strobe is combinational in the accept cycle.
  - Address = inputs_1 when fn[0]=0, else a_ptr/b_ptr; in the latter case the pointer increments, wrapping at 2^A_BITS / 2^B_BITS.
  - Next state RESP, response 0.
- READ_C:
  - Accept cycle drives c_index = inputs_1[C_BITS-1:0] and registers the lane select = inputs_0[2:0].
  - READ state lasts 1 cycle; then RESP.
  - Lane 0 = c_rdata[32*C_LANES-1 -: 32] (MSB lane first). A lane >= C_LANES returns 0.
  - Response data is captured into a register, so it stays stable while rsp_ready is low.
- GO:
  - tpu_in_valid pulses in the cycle after accept, with operands registered. Counter clears to 0.
  - CALC lasts at least 2 cycles, so busy latency is tolerated. CALC exits on the first cycle after the pulse with tpu_busy=0.
  - Counter increments every CALC cycle, saturating at 0xFFFFFFFF.
  - Response = final count.
- GO_ASYNC: same start pulse and counter, but goes to RESP with response 0 and sets run=1. run clears, and the counter freezes, on the first post-pulse cycle with tpu_busy=0.
- STATUS: response = {run, count[30:0]}. Accepted during run.
- SET_PTR: a_ptr = inputs_0[A_BITS-1:0], b_ptr = inputs_1[B_BITS-1:0]. Response 0.
- Reserved code: no side effects; response 0xFFFFFFFF.
- RESP: rsp_valid=1, data held until rsp_ready, then IDLE. rsp_valid and cmd_ready are never both 1.
- Index mux:
  - In CALC or when run=1: a_index/b_index/c_index = the tpu_* inputs, and a_wr_en/b_wr_en are forced 0.
  - Otherwise the indices come from command decode.

Test Plan:
- SET_PTR(0x10,0x20); WRITE_A auto x3 with data 1,2,3 -> writes at A addr 0x10,0x11,0x12; WRITE_B auto at B_BITS=4 with b_ptr=15 -> writes at 15, then 0 (wrap).
- Preload C[5] = 0x11111111_22222222_33333333_44444444; READ_C lane 0..3 -> 0x11111111, 0x22222222, 0x33333333, 0x44444444; lane 5 -> 0; rsp_ready held low 3 cycles -> data stable.
- GO with inputs_0 = {K=16, M=32, N=4}; TPU model busy for 50 cycles -> exactly one tpu_in_valid pulse, tpu_k=16, tpu_m=32, tpu_n=4; response equals the number of CALC cycles; cmd_ready=0 throughout.
- GO_ASYNC, then WRITE_A attempt -> cmd_ready stays 0 until busy drops. STATUS polls -> bit31=1 during the job, 0 after, with a frozen count. Strobes stay 0 during the job.
- Reserved code 7 -> response 0xFFFFFFFF, no buffer strobes.
- Reset asserted in CALC cycle 10 -> next cycle IDLE, rsp_valid=0, run=0, pointers 0; a following WRITE_A completes normally.
